m_vga_timing: RTL and testbench



---
 rtl/m_vga_timing.sv | 86 ++++++++
 tb/tb_m_vga_timing.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_vga_timing.sv
// rtl/m_vga_timing.sv - scan-position, sync, active and strobe generator for the display path
module m_vga_timing #(
    parameter int   H_VISIBLE = 800,
    parameter int   H_FRONT   = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BACK    = 88,
    parameter int   V_VISIBLE = 600,
    parameter int   V_FRONT   = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BACK    = 23,
    parameter logic SYNC_POL  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_pix_en,
    output logic [10:0] current_x,
    output logic [10:0] current_y,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_active,
    output logic        o_line_start,
    output logic        o_frame_start,
    output logic [7:0]  o_frame_cnt
);

    localparam logic [10:0] H_TOTAL   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [10:0] V_TOTAL   = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [10:0] H_VIS     = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS     = 11'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_LO = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_HI = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_SYNC_LO = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_HI = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic        x_wrap;
    logic        y_wrap;
    logic [10:0] x_nxt;
    logic [10:0] y_nxt;
    logic        hsync_nxt;
    logic        vsync_nxt;
    logic        active_nxt;

    // Flags are decoded from the next coordinate so they land in the same cycle as it.
    always_comb begin
        x_wrap     = (current_x == H_TOTAL - 11'd1);
        y_wrap     = (current_y == V_TOTAL - 11'd1);
        x_nxt      = x_wrap ? 11'd0 : current_x + 11'd1;
        y_nxt      = current_y;
        if (x_wrap) begin
            y_nxt = y_wrap ? 11'd0 : current_y + 11'd1;
        end
        hsync_nxt  = (x_nxt >= H_SYNC_LO && x_nxt < H_SYNC_HI) ? SYNC_POL : ~SYNC_POL;
        vsync_nxt  = (y_nxt >= V_SYNC_LO && y_nxt < V_SYNC_HI) ? SYNC_POL : ~SYNC_POL;
        active_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_x     <= 11'd0;
            current_y     <= 11'd0;
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_active      <= 1'b1;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_cnt   <= 8'd0;
        end else begin
            // Strobes default low so a sparse enable yields a single-clk pulse.
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            if (i_pix_en) begin
                current_x     <= x_nxt;
                current_y     <= y_nxt;
                o_hsync       <= hsync_nxt;
                o_vsync       <= vsync_nxt;
                o_active      <= active_nxt;
                o_line_start  <= x_wrap;
                o_frame_start <= x_wrap && y_wrap;
                if (x_wrap && y_wrap) begin
                    o_frame_cnt <= o_frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_m_vga_timing.sv
// tb/tb_m_vga_timing.sv - randomized model-checked bench for m_vga_timing
module tb_m_vga_timing;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        act;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en;

    always #5 clk = ~clk;

    logic [10:0] d_x, d_y, s_x, s_y, n_x, n_y;
    logic        d_hs, d_vs, d_act, d_ls, d_fs;
    logic        s_hs, s_vs, s_act, s_ls, s_fs;
    logic        n_hs, n_vs, n_act, n_ls, n_fs;
    logic [7:0]  d_fc, s_fc, n_fc;

    m_vga_timing dut_d (
        .clk(clk), .rst_n(rst_n), .i_pix_en(pix_en),
        .current_x(d_x), .current_y(d_y), .o_hsync(d_hs), .o_vsync(d_vs),
        .o_active(d_act), .o_line_start(d_ls), .o_frame_start(d_fs), .o_frame_cnt(d_fc)
    );

    m_vga_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .i_pix_en(pix_en),
        .current_x(s_x), .current_y(s_y), .o_hsync(s_hs), .o_vsync(s_vs),
        .o_active(s_act), .o_line_start(s_ls), .o_frame_start(s_fs), .o_frame_cnt(s_fc)
    );

    m_vga_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .i_pix_en(pix_en),
        .current_x(n_x), .current_y(n_y), .o_hsync(n_hs), .o_vsync(n_vs),
        .o_active(n_act), .o_line_start(n_ls), .o_frame_start(n_fs), .o_frame_cnt(n_fc)
    );

    obs_t act_d, act_s, act_n;
    assign act_d = {d_x, d_y, d_hs, d_vs, d_act, d_ls, d_fs, d_fc};
    assign act_s = {s_x, s_y, s_hs, s_vs, s_act, s_ls, s_fs, s_fc};
    assign act_n = {n_x, n_y, n_hs, n_vs, n_act, n_ls, n_fs, n_fc};

    int n_checks = 0;
    int n_fails  = 0;
    bit checking = 0;

    // Model state: enabled pixels since reset, and whether the last edge was enabled.
    int p = 0;
    bit last_en = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p       <= 0;
            last_en <= 0;
        end else begin
            last_en <= pix_en;
            if (pix_en) p <= p + 1;
        end
    end

    function automatic obs_t model(int pix, bit le, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb, bit pol);
        obs_t e;
        int ht = hv + hf + hsw + hb;
        int vt = vv + vf + vsw + vb;
        int x  = pix % ht;
        int y  = (pix / ht) % vt;
        e.x   = 11'(x);
        e.y   = 11'(y);
        e.hs  = (x >= hv + hf && x < hv + hf + hsw) ? pol : !pol;
        e.vs  = (y >= vv + vf && y < vv + vf + vsw) ? pol : !pol;
        e.act = (x < hv) && (y < vv);
        e.ls  = le && (x == 0);
        e.fs  = le && (x == 0) && (y == 0);
        e.fc  = 8'((pix / (ht * vt)) % 256);
        return e;
    endfunction

    task automatic finish_now();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    endtask

    task automatic chk(string name, int actual, int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
            if (n_fails >= 50) finish_now();
        end
    endtask

    task automatic cmp_obs(string tag, obs_t a, obs_t e);
        n_checks++;
        if (a !== e) begin
            n_fails++;
            $display("FAIL %s p=%0d: got x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d",
                     tag, p, a.x, a.y, a.hs, a.vs, a.act, a.ls, a.fs, a.fc,
                     e.x, e.y, e.hs, e.vs, e.act, e.ls, e.fs, e.fc);
            if (n_fails >= 50) finish_now();
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            cmp_obs("default", act_d, model(p, last_en, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1));
            cmp_obs("small",   act_s, model(p, last_en, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1));
            cmp_obs("neg_pol", act_n, model(p, last_en, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0));
        end
    end

    // Apply one enable value for exactly one rising edge; returns 2ns after that edge.
    task automatic step(bit en);
        pix_en = en;
        @(posedge clk);
        #2;
        pix_en = 1'b0;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_x"},   d_x, 0);
        chk({tag, "_y"},   d_y, 0);
        chk({tag, "_hs"},  d_hs, 0);
        chk({tag, "_vs"},  d_vs, 0);
        chk({tag, "_act"}, d_act, 1);
        chk({tag, "_ls"},  d_ls, 0);
        chk({tag, "_fs"},  d_fs, 0);
        chk({tag, "_fc"},  d_fc, 0);
        chk({tag, "_n_hs"}, n_hs, 1);
        chk({tag, "_n_vs"}, n_vs, 1);
    endtask

    initial begin
        int cyc;
        rst_n  = 1'b0;
        pix_en = 1'b0;
        @(posedge clk);
        #2;
        checking = 1;
        chk_reset_vals("reset");
        step(0);
        step(0);
        rst_n = 1'b1;

        // First enabled edge moves x to 1 without a strobe.
        step(1);
        chk("first_x", d_x, 1);
        chk("first_ls", d_ls, 0);
        repeat (799) step(1);
        chk("x800", d_x, 800);
        chk("act_fall", d_act, 0);
        repeat (40) step(1);
        chk("hs_rise_x", d_x, 840);
        chk("hs_rise", d_hs, 1);
        repeat (127) step(1);
        chk("hs_last", d_hs, 1);
        step(1);
        chk("hs_fall_x", d_x, 968);
        chk("hs_fall", d_hs, 0);
        repeat (88) step(1);
        chk("line_x", d_x, 0);
        chk("line_y", d_y, 1);
        chk("line_act", d_act, 1);
        chk("line_ls", d_ls, 1);
        chk("line_fs", d_fs, 0);

        // Sparse enable: strobes must stay single-clk.
        for (int i = 0; i < 400; i++) step(i % 4 == 0);
        repeat (100) step(0);

        // Mid-frame reset takes effect without a clock edge.
        repeat (37) step(1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        step(1);
        step(0);
        rst_n = 1'b1;

        // Small instance: line wrap after 15 pixels, frame wrap after 120.
        repeat (15) step(1);
        chk("s_line_x", s_x, 0);
        chk("s_line_y", s_y, 1);
        chk("s_line_ls", s_ls, 1);
        chk("s_line_fs", s_fs, 0);
        step(0);
        chk("s_line_ls_drop", s_ls, 0);
        repeat (105) step(1);
        chk("s_frame_x", s_x, 0);
        chk("s_frame_y", s_y, 0);
        chk("s_frame_ls", s_ls, 1);
        chk("s_frame_fs", s_fs, 1);
        chk("s_frame_fc", s_fc, 1);

        // Random enable until 256 frames have completed on the small instance.
        cyc = 0;
        while (p < 256 * 120 && cyc < 60000) begin
            step($urandom_range(3) != 0);
            cyc++;
        end
        chk("wrap_reached", (p == 256 * 120) ? 1 : 0, 1);
        if (last_en) begin
            chk("fc_wrap", s_fc, 0);
            chk("fc_wrap_fs", s_fs, 1);
        end
        repeat (50) step($urandom_range(1));
        step(0);
        checking = 0;
        finish_now();
    end

endmodule
